// File: rtl/riscv_seq_pkg.sv
// Shared definitions for the instruction phase sequencer.
//   PHASE_W      width of the phase/state code
//   seq_state_e  sequencer states; the value is also the externally visible phase code
//   cnt_w()      width needed for a down-counter that must hold max_val
package riscv_seq_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_MEM       = 3'd5,
    ST_WB        = 3'd6,
    ST_HALT      = 3'd7
  } seq_state_e;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/riscv_phase_seq_if.sv
// Control/status bundle between the phase sequencer and the datapath.
//   master: the sequencer (drives phase enables and status, reads run/decode/ALU inputs)
//   slave : the datapath/controller side
interface riscv_phase_seq_if #(
  parameter int unsigned CNT_W = 32
);
  logic                                run;
  logic                                halt_req;
  logic                                is_multicyc;
  logic                                is_mem;
  logic                                alu_complete;
  logic                                en_fetch;
  logic                                en_decode;
  logic                                en_alu;
  logic                                en_mem;
  logic                                en_wb;
  logic [riscv_seq_pkg::PHASE_W-1:0]   phase;
  logic                                retire;
  logic                                halted;
  logic                                timeout_err;
  logic [CNT_W-1:0]                    instr_cnt;

  modport master (
    input  run, halt_req, is_multicyc, is_mem, alu_complete,
    output en_fetch, en_decode, en_alu, en_mem, en_wb,
    output phase, retire, halted, timeout_err, instr_cnt
  );

  modport slave (
    output run, halt_req, is_multicyc, is_mem, alu_complete,
    input  en_fetch, en_decode, en_alu, en_mem, en_wb,
    input  phase, retire, halted, timeout_err, instr_cnt
  );
endinterface

// File: rtl/seq_wait_cnt.sv
// Loadable down-counter with a zero flag.
//   clk, rst  clock and asynchronous active-high reset (count clears to 0)
//   load      load load_val (has priority over dec)
//   dec       decrement by one, saturating at zero
//   done      count is zero
module seq_wait_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/riscv_phase_seq.sv
// Instruction phase sequencer: one-cycle phase enables on a single clock,
// EXEC stall for multi-cycle ALU ops with timeout, fixed-length MEM phase,
// retired-instruction counter.
//   clk, rst  system clock, asynchronous active-high reset
//   bus       riscv_phase_seq_if.master (run/decode/ALU inputs, phase enables and status)
module riscv_phase_seq
  import riscv_seq_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 64,
  parameter int unsigned MEM_WAIT    = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  riscv_phase_seq_if.master   bus
);

  localparam int unsigned ALU_CW = cnt_w(ALU_TIMEOUT - 1);
  localparam int unsigned MEM_CW = cnt_w(MEM_WAIT - 1);
  localparam logic [ALU_CW-1:0] ALU_LOAD = ALU_CW'(ALU_TIMEOUT - 1);
  localparam logic [MEM_CW-1:0] MEM_LOAD = MEM_CW'(MEM_WAIT - 1);

  seq_state_e       state_q, state_d;
  logic             mc_q, mc_d;
  logic             mem_q, mem_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic alu_load, alu_dec, alu_done;
  logic mem_load, mem_dec, mem_done;

  // Counters are preloaded to length-1 on entry so that done marks the last cycle.
  seq_wait_cnt #(.W(ALU_CW)) u_alu_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (alu_load),
    .load_val (ALU_LOAD),
    .dec      (alu_dec),
    .done     (alu_done)
  );

  seq_wait_cnt #(.W(MEM_CW)) u_mem_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (mem_load),
    .load_val (MEM_LOAD),
    .dec      (mem_dec),
    .done     (mem_done)
  );

  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    mem_d    = mem_q;
    terr_d   = terr_q;
    cnt_d    = cnt_q;
    alu_load = 1'b0;
    alu_dec  = 1'b0;
    mem_load = 1'b0;
    mem_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        mc_d    = bus.is_multicyc;
        mem_d   = bus.is_mem;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (mc_q) begin
          alu_load = 1'b1;
          state_d  = ST_EXEC_WAIT;
        end else begin
          mem_load = mem_q;
          state_d  = mem_q ? ST_MEM : ST_WB;
        end
      end
      ST_EXEC_WAIT: begin
        // Completion is tested first so it wins over a same-cycle timeout.
        if (bus.alu_complete) begin
          mem_load = mem_q;
          state_d  = mem_q ? ST_MEM : ST_WB;
        end else if (alu_done) begin
          terr_d  = 1'b1;
          state_d = ST_HALT;
        end else begin
          alu_dec = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_done) state_d = ST_WB;
        else          mem_dec = 1'b1;
      end
      ST_WB: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.halt_req) state_d = ST_HALT;
        else if (bus.run) state_d = ST_FETCH;
        else              state_d = ST_IDLE;
      end
      ST_HALT: begin
        // A timeout halt is terminal until reset.
        if (!terr_q && !bus.halt_req && bus.run) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mc_q    <= 1'b0;
      mem_q   <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mem_q   <= mem_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.en_fetch  = 1'b0;
    bus.en_decode = 1'b0;
    bus.en_alu    = 1'b0;
    bus.en_mem    = 1'b0;
    bus.en_wb     = 1'b0;
    bus.retire    = 1'b0;
    bus.halted    = 1'b0;
    case (state_q)
      ST_FETCH:  bus.en_fetch  = 1'b1;
      ST_DECODE: bus.en_decode = 1'b1;
      ST_EXEC:   bus.en_alu    = 1'b1;
      ST_MEM:    bus.en_mem    = 1'b1;
      ST_WB: begin
        bus.en_wb  = 1'b1;
        bus.retire = 1'b1;
      end
      ST_HALT:   bus.halted    = 1'b1;
      default: ;
    endcase
  end

  assign bus.phase       = state_q;
  assign bus.timeout_err = terr_q;
  assign bus.instr_cnt   = cnt_q;

endmodule
